// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the four requesters, the UART transmitter and the arbiter.
// Handshakes:
// - A requester holds req_valid[k] with its byte until it sees the one-cycle
//   req_ready[k] acknowledge, then drops or updates it.
// - tx_start is a one-cycle launch with tx_byte stable.
// - tx_done is a one-cycle completion pulse from the transmitter.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;
  logic [1:0]  err_id;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_byte, grant_id, busy, err, err_id
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_byte, grant_id, busy, err, err_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte requesters,
// with a completion timeout and an idle guard gap between transfers.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd20000,
  parameter logic [3:0]  GAP     = 4'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_arbiter_if.master     bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  ptr;
  logic [15:0] timer;
  logic [3:0]  gap_cnt;
  logic [7:0]  tx_byte_q;
  logic [1:0]  grant_q;
  logic        err_q;
  logic [1:0]  err_id_q;

  logic [1:0]  winner;
  logic [1:0]  cand;
  logic        found;
  logic        err_set;

  // Walk from the farthest offset down so the first set bit after ptr wins.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = |bus.req_valid;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (bus.req_valid[cand]) winner = cand;
    end
  end

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    case (state)
      S_IDLE:   if (found) state_n = S_LAUNCH;
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        // Completion beats a coincident timeout.
        if (bus.tx_done) begin
          state_n = (GAP == 4'd0) ? S_IDLE : S_GAP;
        end else if (timer == TIMEOUT - 16'd1) begin
          err_set = 1'b1;
          state_n = (GAP == 4'd0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP:    if (gap_cnt == GAP - 4'd1) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      timer     <= 16'd0;
      gap_cnt   <= 4'd0;
      tx_byte_q <= 8'h00;
      grant_q   <= 2'd0;
      err_q     <= 1'b0;
      err_id_q  <= 2'd0;
    end else begin
      state <= state_n;
      err_q <= err_set;
      if (err_set) err_id_q <= grant_q;
      case (state)
        S_IDLE: begin
          if (found) begin
            tx_byte_q <= bus.req_data[{winner, 3'b000} +: 8];
            grant_q   <= winner;
            ptr       <= winner + 2'd1;
          end
        end
        S_LAUNCH: timer <= 16'd0;
        S_WAIT: begin
          timer   <= timer + 16'd1;
          gap_cnt <= 4'd0;
        end
        S_GAP:    gap_cnt <= gap_cnt + 4'd1;
        default:  ;
      endcase
    end
  end

  assign bus.req_ready = (state == S_LAUNCH) ? (4'b0001 << grant_q) : 4'b0000;
  assign bus.tx_start  = (state == S_LAUNCH);
  assign bus.tx_byte   = tx_byte_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;
  assign bus.err_id    = err_id_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, launch/timeout timing,
// reset abandonment and back-to-back period with a zero guard gap.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if a_if ();
  uart_tx_arbiter_if b_if ();
  logic [1:0] a_state;
  logic [1:0] b_state;

  uart_tx_arbiter #(.TIMEOUT(16'd8), .GAP(4'd2)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.master), .state_dbg(a_state)
  );

  uart_tx_arbiter #(.TIMEOUT(16'd8), .GAP(4'd0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.master), .state_dbg(b_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [9:0] exp_q[$];   // {grant_id, tx_byte}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the launch cycle of dut_a and scores it.
  task automatic wait_launch(input string tag);
    int n;
    logic [9:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_if.tx_start !== 1'b1 && n < 40);
    chk({tag, "_start"}, 32'(a_if.tx_start), 32'd1);
    chk({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
    chk({tag, "_grant"}, 32'(a_if.grant_id), 32'(e[9:8]));
    chk({tag, "_byte"},  32'(a_if.tx_byte),  32'(e[7:0]));
    chk({tag, "_ready"}, 32'(a_if.req_ready), 32'(4'b0001 << e[9:8]));
  endtask

  // From the launch cycle: pulse tx_done when the WAIT timer reads w.
  task automatic complete(input string tag, input int w);
    @(negedge clk);
    chk({tag, "_start_1cyc"}, 32'(a_if.tx_start), 32'd0);
    chk({tag, "_ready_1cyc"}, 32'(a_if.req_ready), 32'd0);
    repeat (w) @(negedge clk);
    a_if.tx_done = 1'b1;
    @(negedge clk);
    a_if.tx_done = 1'b0;
  endtask

  initial begin
    int n;
    int c0;
    a_if.req_valid = 4'h0; a_if.req_data = 32'h0; a_if.tx_done = 1'b0;
    b_if.req_valid = 4'h0; b_if.req_data = 32'h0; b_if.tx_done = 1'b0;

    // Reset values, before any clock edge
    #1;
    chk("rst_busy",   32'(a_if.busy),      32'd0);
    chk("rst_start",  32'(a_if.tx_start),  32'd0);
    chk("rst_ready",  32'(a_if.req_ready), 32'd0);
    chk("rst_byte",   32'(a_if.tx_byte),   32'd0);
    chk("rst_grant",  32'(a_if.grant_id),  32'd0);
    chk("rst_err",    32'(a_if.err),       32'd0);
    chk("rst_err_id", 32'(a_if.err_id),    32'd0);
    chk("rst_state",  32'(a_state),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 2 with byte A5
    a_if.req_data  = 32'h00A5_0000;
    a_if.req_valid = 4'b0100;
    exp_q.push_back({2'd2, 8'hA5});
    wait_launch("s35");
    a_if.req_valid = 4'b0000;
    complete("s35", 5);
    chk("s35_gap0_busy", 32'(a_if.busy), 32'd1);
    @(negedge clk);
    chk("s35_gap1_busy", 32'(a_if.busy), 32'd1);
    @(negedge clk);
    chk("s35_idle_busy", 32'(a_if.busy),     32'd0);
    chk("s35_hold_grant", 32'(a_if.grant_id), 32'd2);
    chk("s35_hold_byte", 32'(a_if.tx_byte),  32'hA5);
    chk("s35_no_err",    32'(a_if.err),      32'd0);

    // Reset pointer back to 0, then all four requesters held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_if.req_data  = 32'h4433_2211;
    a_if.req_valid = 4'hF;
    exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd2, 8'h33});
    exp_q.push_back({2'd3, 8'h44});
    exp_q.push_back({2'd0, 8'h11});
    for (int k = 0; k < 5; k++) begin
      wait_launch("s36");
      if (k == 4) a_if.req_valid = 4'h0;
      complete("s36", 2);
    end
    repeat (2) @(negedge clk);
    chk("s36_idle", 32'(a_if.busy), 32'd0);

    // Timeout on requester 3; requester 0 arrives mid-transfer
    a_if.req_valid = 4'b1000;
    exp_q.push_back({2'd3, 8'h44});
    wait_launch("s37");
    a_if.req_valid = 4'b0001;
    exp_q.push_back({2'd0, 8'h11});
    repeat (8) @(negedge clk);
    chk("s37_err_early", 32'(a_if.err), 32'd0);
    @(negedge clk);
    chk("s37_err",      32'(a_if.err),    32'd1);
    chk("s37_err_id",   32'(a_if.err_id), 32'd3);
    chk("s37_err_busy", 32'(a_if.busy),   32'd1);
    @(negedge clk);
    chk("s37_err_1cyc", 32'(a_if.err),    32'd0);
    wait_launch("s37n");
    a_if.req_valid = 4'h0;

    // tx_done coincides with timer == TIMEOUT-1
    complete("s38", 7);
    chk("s38_no_err",  32'(a_if.err),    32'd0);
    chk("s38_err_id",  32'(a_if.err_id), 32'd3);
    chk("s38_gap",     32'(a_if.busy),   32'd1);
    repeat (2) @(negedge clk);
    chk("s38_idle",    32'(a_if.busy),   32'd0);

    // Reset during WAIT, stray tx_done afterwards
    a_if.req_valid = 4'b0100;
    exp_q.push_back({2'd2, 8'h33});
    wait_launch("s39");
    a_if.req_valid = 4'h0;
    repeat (3) @(negedge clk);
    chk("s39_in_wait", 32'(a_state), 32'd2);
    rst = 1'b1;
    #1;
    chk("s39_rst_busy",   32'(a_if.busy),      32'd0);
    chk("s39_rst_start",  32'(a_if.tx_start),  32'd0);
    chk("s39_rst_byte",   32'(a_if.tx_byte),   32'd0);
    chk("s39_rst_grant",  32'(a_if.grant_id),  32'd0);
    chk("s39_rst_err_id", 32'(a_if.err_id),    32'd0);
    chk("s39_rst_err",    32'(a_if.err),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    a_if.tx_done = 1'b1;
    @(negedge clk);
    a_if.tx_done = 1'b0;
    chk("s39_stray_busy", 32'(a_if.busy), 32'd0);
    chk("s39_stray_err",  32'(a_if.err),  32'd0);
    a_if.req_valid = 4'hF;
    exp_q.push_back({2'd0, 8'h11});
    wait_launch("s39w");
    a_if.req_valid = 4'h0;
    complete("s39w", 1);
    repeat (2) @(negedge clk);

    // Zero guard gap: period = 3 + wait cycles
    b_if.req_data  = 32'h0000_00C3;
    b_if.req_valid = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_if.tx_start !== 1'b1 && n < 40);
    chk("s40_start", 32'(b_if.tx_start), 32'd1);
    chk("s40_grant", 32'(b_if.grant_id), 32'd0);
    chk("s40_ready", 32'(b_if.req_ready), 32'd1);
    c0 = cyc;
    repeat (4) @(negedge clk);
    b_if.tx_done = 1'b1;
    @(negedge clk);
    b_if.tx_done = 1'b0;
    chk("s40_idle", 32'(b_if.busy), 32'd0);
    @(negedge clk);
    chk("s40_restart", 32'(b_if.tx_start), 32'd1);
    chk("s40_period",  32'(cyc - c0),      32'd6);
    chk("s40_byte",    32'(b_if.tx_byte),  32'hC3);
    b_if.req_valid = 4'h0;
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
